// File: rtl/key_command_arbiter_pkg.sv
// Shared types for the key input path: key index width and arbiter states.
package gol_input_pkg;
    localparam int NKEYS_DEFAULT = 4;

    typedef logic [$clog2(NKEYS_DEFAULT)-1:0] key_idx_t;

    typedef enum logic {
        IDLE,
        OFFER
    } arb_state_t;
endpackage

// File: rtl/key_command_arbiter_if.sv
// Valid/ready command channel carrying the index of a pressed key.
interface key_command_arbiter_if #(
    parameter int NKEYS = 4
);
    localparam int IDW = (NKEYS > 2) ? $clog2(NKEYS) : 1;

    logic           cmd_valid;
    logic           cmd_ready;
    logic [IDW-1:0] cmd_id;

    modport master (output cmd_valid, output cmd_id, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_id, output cmd_ready);
endinterface

// File: rtl/key_command_arbiter_debounce.sv
// One key: two-flop synchroniser, stability counter and a press pulse on 1->0.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic press_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          s1_q, s2_q, stable_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_d;
    logic          cnt_done;

    assign cnt_done = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q + 1'b1;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_done) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end
    end

    // Pulses on the same edge that commits the new low level.
    assign press_o = stable_q & ~s2_q & cnt_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            s1_q     <= key_n_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/key_command_arbiter.sv
// Debounced key presses queued as pending flags, shared round-robin over one command channel.
module key_command_arbiter
    import gol_input_pkg::*;
#(
    parameter int NKEYS           = NKEYS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NKEYS-1:0]            key_n_i,
    key_command_arbiter_if.master       cmd,
    output logic [NKEYS-1:0]            pending_o,
    output logic                        dropped_o
);
    localparam int IDW = (NKEYS > 2) ? $clog2(NKEYS) : 1;

    arb_state_t     state_q;
    logic           valid_q;
    logic [IDW-1:0] id_q, last_grant_q;
    logic [NKEYS-1:0] pending_q, pending_d, press, grant_mask;
    logic           dropped_q, dropped_d;
    logic           grant;
    logic           sel_found;
    logic [IDW-1:0] sel_idx;

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk     (clk),
            .rst     (rst),
            .key_n_i (key_n_i[i]),
            .press_o (press[i])
        );
    end

    assign grant      = (state_q == OFFER) && cmd.cmd_ready;
    assign grant_mask = grant ? (NKEYS'(1) << id_q) : '0;

    // A press wins over a same-edge grant so the new request stays queued.
    always_comb begin
        pending_d = (pending_q & ~grant_mask) | press;
        dropped_d = |(press & pending_q & ~grant_mask);
    end

    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int off = 1; off <= NKEYS; off++) begin
            idx = (int'(last_grant_q) + off) % NKEYS;
            if (!sel_found && pending_q[idx]) begin
                sel_found = 1'b1;
                sel_idx   = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            id_q         <= '0;
            last_grant_q <= IDW'(NKEYS - 1);
            pending_q    <= '0;
            dropped_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            dropped_q <= dropped_d;
            case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        id_q    <= sel_idx;
                        valid_q <= 1'b1;
                        state_q <= OFFER;
                    end
                end
                OFFER: begin
                    if (cmd.cmd_ready) begin
                        last_grant_q <= id_q;
                        valid_q      <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd.cmd_valid = valid_q;
    assign cmd.cmd_id    = id_q;
    assign pending_o     = pending_q;
    assign dropped_o     = dropped_q;
endmodule
